// File: rtl/driver_display_varredura_pkg.sv
// Shared types, constants and helpers for the multiplexed 7-segment scan driver.
// Digit-enable vectors are handled at HAB_MAX width and truncated by the user.
package pkg_display;

    typedef enum logic {
        APAGA = 1'b0,
        EXIBE = 1'b1
    } estado_varredura_t;

    localparam logic [6:0] SEG_APAGADO = 7'b0;
    localparam int         HAB_MAX     = 32;

    // Applies the digit-enable polarity to a one-hot (or all-zero) vector.
    function automatic logic [HAB_MAX-1:0] hab_polaridade(
        input logic [HAB_MAX-1:0] um_quente,
        input bit                 ativo_baixo
    );
        return ativo_baixo ? ~um_quente : um_quente;
    endfunction

    function automatic int largura_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/driver_display_varredura_if.sv
// Bundle between the channel digit encoders, the scan driver and the panel pins.
// fimQuadro is the only strobe: a one-cycle pulse with no back-pressure; every other signal is a level.
interface driver_display_varredura_if #(
    parameter int N_CANAIS  = 2,
    parameter int N_DIGITOS = 4
);
    import pkg_display::*;

    localparam int CW = largura_min1(N_CANAIS);

    logic                           modoAuto;
    logic [CW-1:0]                  selecaoManual;
    logic [N_CANAIS*N_DIGITOS*7-1:0] segEntrada;
    logic [6:0]                     segmentos;
    logic [N_DIGITOS-1:0]           habDigito;
    logic [CW-1:0]                  canalAtivo;
    logic                           fimQuadro;
    estado_varredura_t              estadoVarredura;

    modport master (
        output modoAuto, selecaoManual, segEntrada,
        input  segmentos, habDigito, canalAtivo, fimQuadro, estadoVarredura
    );

    modport slave (
        input  modoAuto, selecaoManual, segEntrada,
        output segmentos, habDigito, canalAtivo, fimQuadro, estadoVarredura
    );

endinterface

// File: rtl/driver_display_varredura_temporizador.sv
// Blanking/display timing for one digit slot: APAGA for CICLOS_APAGA cycles, then EXIBE for CICLOS_DIGITO.
// inicioExibe_o and fimDigito_o are high in the last cycle of their state, i.e. one edge before the switch.
module temporizador_varredura
    import pkg_display::*;
#(
    parameter int CICLOS_APAGA  = 8,
    parameter int CICLOS_DIGITO = 50000
) (
    input  logic              clock,
    input  logic              reset_n,
    output estado_varredura_t estado_o,
    output logic              fimDigito_o,
    output logic              inicioExibe_o
);

    localparam int MAX_CICLOS = (CICLOS_APAGA > CICLOS_DIGITO) ? CICLOS_APAGA : CICLOS_DIGITO;
    localparam int CNT_W      = largura_min1(MAX_CICLOS);
    localparam logic [CNT_W-1:0] FIM_APAGA = CNT_W'(CICLOS_APAGA - 1);
    localparam logic [CNT_W-1:0] FIM_EXIBE = CNT_W'(CICLOS_DIGITO - 1);

    estado_varredura_t estado_q, estado_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= APAGA;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        cnt_d         = cnt_q + CNT_W'(1);
        fimDigito_o   = 1'b0;
        inicioExibe_o = 1'b0;
        case (estado_q)
            APAGA: begin
                if (cnt_q == FIM_APAGA) begin
                    estado_d      = EXIBE;
                    cnt_d         = '0;
                    inicioExibe_o = 1'b1;
                end
            end
            EXIBE: begin
                if (cnt_q == FIM_EXIBE) begin
                    estado_d    = APAGA;
                    cnt_d       = '0;
                    fimDigito_o = 1'b1;
                end
            end
            default: begin
                estado_d = APAGA;
                cnt_d    = '0;
            end
        endcase
    end

    assign estado_o = estado_q;

endmodule

// File: rtl/driver_display_varredura.sv
// N-channel, N-digit multiplexed 7-segment driver with blanking gaps and manual/auto channel choice.
// Pattern and digit enable are loaded on the same edge, so a lit digit never shows a stale pattern.
module driver_display_varredura
    import pkg_display::*;
#(
    parameter int N_CANAIS        = 2,
    parameter int N_DIGITOS       = 4,
    parameter int CICLOS_DIGITO   = 50000,
    parameter int CICLOS_APAGA    = 8,
    parameter int QUADROS_TROCA   = 100,
    parameter int HAB_ATIVO_BAIXO = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    driver_display_varredura_if.slave bus
);

    localparam int CW   = largura_min1(N_CANAIS);
    localparam int IW   = largura_min1(N_DIGITOS);
    localparam int QW   = largura_min1(QUADROS_TROCA);
    localparam bit POL  = (HAB_ATIVO_BAIXO != 0);
    localparam logic [N_DIGITOS-1:0] HAB_INATIVO = N_DIGITOS'(hab_polaridade('0, POL));

    estado_varredura_t estado;
    logic              fim_digito;
    logic              inicio_exibe;

    temporizador_varredura #(
        .CICLOS_APAGA (CICLOS_APAGA),
        .CICLOS_DIGITO(CICLOS_DIGITO)
    ) u_temporizador (
        .clock        (clock),
        .reset_n      (reset_n),
        .estado_o     (estado),
        .fimDigito_o  (fim_digito),
        .inicioExibe_o(inicio_exibe)
    );

    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        canal_q, canal_d;
    logic [QW-1:0]        quadro_q, quadro_d;
    logic                 modo_q, modo_d;
    logic [6:0]           seg_q, seg_d;
    logic [N_DIGITOS-1:0] hab_q, hab_d;
    logic                 fim_q, fim_d;

    logic [CW-1:0]        sel_limitado;
    logic [HAB_MAX-1:0]   um_quente;
    logic [N_DIGITOS-1:0] hab_novo;
    logic [6:0]           padrao;
    int                   pos_padrao;

    always_comb begin
        sel_limitado = bus.selecaoManual;
        if (int'(bus.selecaoManual) >= N_CANAIS) begin
            sel_limitado = CW'(N_CANAIS - 1);
        end
    end

    // Pattern for (canal_q, idx_q), captured only when the digit is about to light.
    always_comb begin
        um_quente  = HAB_MAX'(1) << idx_q;
        hab_novo   = N_DIGITOS'(hab_polaridade(um_quente, POL));
        pos_padrao = (int'(canal_q) * N_DIGITOS + int'(idx_q)) * 7;
        padrao     = 7'(bus.segEntrada >> pos_padrao);
    end

    always_comb begin
        idx_d    = idx_q;
        canal_d  = canal_q;
        quadro_d = quadro_q;
        modo_d   = modo_q;
        seg_d    = seg_q;
        hab_d    = hab_q;
        fim_d    = 1'b0;

        if (inicio_exibe) begin
            seg_d = padrao;
            hab_d = hab_novo;
        end

        if (fim_digito) begin
            seg_d = SEG_APAGADO;
            hab_d = HAB_INATIVO;
            if (idx_q == IW'(N_DIGITOS - 1)) begin
                idx_d = '0;
                fim_d = 1'b1;
                // A mode flip restarts the auto frame count; manual takes the selector right away.
                if (bus.modoAuto != modo_q) begin
                    modo_d   = bus.modoAuto;
                    quadro_d = '0;
                    if (!bus.modoAuto) begin
                        canal_d = sel_limitado;
                    end
                end else if (!bus.modoAuto) begin
                    canal_d = sel_limitado;
                end else if (quadro_q == QW'(QUADROS_TROCA - 1)) begin
                    quadro_d = '0;
                    canal_d  = (canal_q == CW'(N_CANAIS - 1)) ? '0 : canal_q + CW'(1);
                end else begin
                    quadro_d = quadro_q + QW'(1);
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q    <= '0;
            canal_q  <= '0;
            quadro_q <= '0;
            modo_q   <= 1'b0;
            seg_q    <= SEG_APAGADO;
            hab_q    <= HAB_INATIVO;
            fim_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            canal_q  <= canal_d;
            quadro_q <= quadro_d;
            modo_q   <= modo_d;
            seg_q    <= seg_d;
            hab_q    <= hab_d;
            fim_q    <= fim_d;
        end
    end

    assign bus.segmentos       = seg_q;
    assign bus.habDigito       = hab_q;
    assign bus.canalAtivo      = canal_q;
    assign bus.fimQuadro       = fim_q;
    assign bus.estadoVarredura = estado;

endmodule
